// File: rtl/pe_operand_feeder.sv
// Operand feeder for a row of MAC processing elements.
// Accepts k_len operand vectors per job and skews lane i by i cycles, so that
// lane i sees each beat i cycles after lane 0. Bubbles travel through the skew as
// zero data with valid low. After the last beat the FSM waits for the skew and
// the downstream MAC pipeline to drain, then pulses done.
module pe_operand_feeder #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ROWS       = 4,
   parameter int unsigned K_WIDTH    = 16,
   parameter int unsigned PE_LAT     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [K_WIDTH-1:0]           k_len,
   output logic                         busy,
   output logic                         done,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
   input  logic [ROWS*DATA_WIDTH-1:0]   in_weight,
   output logic [ROWS*DATA_WIDTH-1:0]   pe_data,
   output logic [ROWS*DATA_WIDTH-1:0]   pe_weight,
   output logic [ROWS-1:0]              pe_valid,
   output logic [ROWS-1:0]              pe_accumulate_en,
   output logic [ROWS-1:0]              pe_clear_acc
);

   // Skew drain plus MAC pipeline depth; a zero-length drain still spends one cycle in FLUSH.
   localparam int unsigned FlushLen  = ROWS - 1 + PE_LAT;
   localparam int unsigned FlushLast = (FlushLen > 0) ? FlushLen - 1 : 0;
   localparam int unsigned FlushW    = (FlushLen > 1) ? $clog2(FlushLen) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StFeed,
      StFlush,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic [K_WIDTH-1:0] cnt_q, cnt_d;
   logic [K_WIDTH-1:0] k_q, k_d;
   logic [FlushW-1:0]  flush_q, flush_d;
   logic               clear_q, clear_d;

   logic               accept;
   logic               beat_acc;
   logic [K_WIDTH-1:0] cnt_inc;

   // in_ready depends on state only, never on in_valid.
   assign in_ready = (state_q == StFeed);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign cnt_inc  = cnt_q + K_WIDTH'(1);
   // Every beat except the first of the job accumulates onto the cleared accumulator.
   assign beat_acc = (cnt_q != '0);
   assign pe_clear_acc = {ROWS{clear_q}};

   // Control state, beat counter, latched length and flush counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         k_q     <= '0;
         flush_q <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         flush_q <= flush_d;
         clear_q <= clear_d;
      end
   end

   // Next-state logic for the job FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      flush_d = flush_q;
      clear_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               k_d     = k_len;
               cnt_d   = '0;
               clear_d = 1'b1;
               state_d = (k_len == '0) ? StDone : StFeed;
            end
         end
         StFeed: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (cnt_inc == k_q) begin
                  state_d = StFlush;
                  flush_d = '0;
               end
            end
         end
         StFlush: begin
            if (flush_q == FlushW'(FlushLast)) begin
               state_d = StDone;
            end else begin
               flush_d = flush_q + FlushW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Lane i owns a delay line of i+1 registers; stage 0 captures the beat or a bubble.
   for (genvar i = 0; i < ROWS; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] d_q [i+1];
      logic [DATA_WIDTH-1:0] w_q [i+1];
      logic                  v_q [i+1];
      logic                  a_q [i+1];

      // Skew shift register for this lane, flushed to zero by reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k <= i; k++) begin
               d_q[k] <= '0;
               w_q[k] <= '0;
               v_q[k] <= 1'b0;
               a_q[k] <= 1'b0;
            end
         end else begin
            d_q[0] <= accept ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            w_q[0] <= accept ? in_weight[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            v_q[0] <= accept;
            a_q[0] <= accept && beat_acc;
            for (int k = 1; k <= i; k++) begin
               d_q[k] <= d_q[k-1];
               w_q[k] <= w_q[k-1];
               v_q[k] <= v_q[k-1];
               a_q[k] <= a_q[k-1];
            end
         end
      end

      assign pe_data[i*DATA_WIDTH +: DATA_WIDTH]   = d_q[i];
      assign pe_weight[i*DATA_WIDTH +: DATA_WIDTH] = w_q[i];
      assign pe_valid[i]                           = v_q[i];
      assign pe_accumulate_en[i]                   = a_q[i];
   end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder with ROWS=4, PE_LAT=3, DATA_WIDTH=8.
module tb_pe_operand_feeder;

   localparam int unsigned DW = 8;
   localparam int unsigned R  = 4;
   localparam int unsigned KW = 16;
   localparam int unsigned PL = 3;

   logic            clk;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            in_valid;
   logic            in_ready;
   logic [R*DW-1:0] in_data;
   logic [R*DW-1:0] in_weight;
   logic [R*DW-1:0] pe_data;
   logic [R*DW-1:0] pe_weight;
   logic [R-1:0]    pe_valid;
   logic [R-1:0]    pe_accumulate_en;
   logic [R-1:0]    pe_clear_acc;

   int checks   = 0;
   int failures = 0;

   // Expected pe_valid after edge e of the backpressure job (index 0 unused).
   logic [3:0] bp_valid [0:13] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hB, 4'h6, 4'hD,
                                   4'hA, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
   logic       bp_in [1:6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   pe_operand_feeder #(
      .DATA_WIDTH (DW),
      .ROWS       (R),
      .K_WIDTH    (KW),
      .PE_LAT     (PL)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .k_len            (k_len),
      .busy             (busy),
      .done             (done),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_weight        (in_weight),
      .pe_data          (pe_data),
      .pe_weight        (pe_weight),
      .pe_valid         (pe_valid),
      .pe_accumulate_en (pe_accumulate_en),
      .pe_clear_acc     (pe_clear_acc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane i of beat b carries 16*b+i.
   function automatic logic [31:0] mk(input int b);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(16 * b + i);
      return v;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_rdy"},   32'(in_ready), 32'd0);
      chk({tag, "_valid"}, 32'(pe_valid), 32'd0);
      chk({tag, "_acc"},   32'(pe_accumulate_en), 32'd0);
      chk({tag, "_clr"},   32'(pe_clear_acc), 32'd0);
      chk({tag, "_data"},  pe_data, 32'd0);
      chk({tag, "_wgt"},   pe_weight, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int lane_cnt [4];
      int done_cnt;
      int clr_cnt;
      int stray;

      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
      in_data = '0; in_weight = '0;
      tick();
      tick();
      chk_quiet("por");
      rst = 1'b0;
      tick();

      // Streaming job, k_len=3, in_valid held high.
      start = 1'b1; k_len = 16'd3; in_valid = 1'b1; in_data = mk(0); in_weight = ~mk(0);
      tick();                                              // edge 0: start accepted
      chk("st0_clr",   32'(pe_clear_acc), 32'hF);
      chk("st0_busy",  32'(busy), 32'd1);
      chk("st0_rdy",   32'(in_ready), 32'd1);
      chk("st0_valid", 32'(pe_valid), 32'd0);
      start = 1'b0; k_len = 16'hFFFF;
      tick();                                              // edge 1: beat 0
      chk("st1_valid", 32'(pe_valid), 32'h1);
      chk("st1_wgt0",  32'(pe_weight[7:0]), 32'hFF);
      chk("st1_acc",   32'(pe_accumulate_en), 32'h0);
      chk("st1_clr",   32'(pe_clear_acc), 32'h0);
      in_data = mk(1); in_weight = ~mk(1);
      tick();                                              // edge 2: beat 1
      chk("st2_valid", 32'(pe_valid), 32'h3);
      chk("st2_d0",    32'(pe_data[7:0]), 32'h10);
      chk("st2_d1",    32'(pe_data[15:8]), 32'h01);
      chk("st2_acc",   32'(pe_accumulate_en), 32'h1);
      in_data = mk(2); in_weight = ~mk(2);
      tick();                                              // edge 3: beat 2, enter FLUSH
      chk("st3_valid", 32'(pe_valid), 32'h7);
      chk("st3_acc",   32'(pe_accumulate_en), 32'h3);
      chk("st3_rdy",   32'(in_ready), 32'd0);
      chk("st3_d2",    32'(pe_data[23:16]), 32'h02);
      in_data = mk(3); in_weight = ~mk(3);
      tick();
      chk("st4_valid", 32'(pe_valid), 32'hE);
      chk("st4_data",  pe_data, 32'h03122100);
      chk("st4_acc",   32'(pe_accumulate_en), 32'h6);
      chk("st4_w3",    32'(pe_weight[31:24]), 32'hFC);
      tick();
      chk("st5_valid", 32'(pe_valid), 32'hC);
      chk("st5_d3",    32'(pe_data[31:24]), 32'h13);
      chk("st5_acc",   32'(pe_accumulate_en), 32'hC);
      tick();
      chk("st6_valid", 32'(pe_valid), 32'h8);
      chk("st6_data",  pe_data, 32'h23000000);
      chk("st6_acc",   32'(pe_accumulate_en), 32'h8);
      tick();
      chk("st7_valid", 32'(pe_valid), 32'h0);
      chk("st7_data",  pe_data, 32'h0);
      tick();
      chk("st8_done",  32'(done), 32'd0);
      chk("st8_busy",  32'(busy), 32'd1);
      tick();
      chk("st9_done",  32'(done), 32'd1);
      chk("st9_busy",  32'(busy), 32'd1);
      tick();
      chk("st10_done", 32'(done), 32'd0);
      chk("st10_busy", 32'(busy), 32'd0);
      chk("st10_rdy",  32'(in_ready), 32'd0);
      in_valid = 1'b0;
      tick();

      // Backpressure job, k_len=4, in_valid 1,0,1,1,0,1 then held high during flush.
      start = 1'b1; k_len = 16'd4;
      tick();                                              // edge 0
      start = 1'b0;
      b = 0;
      for (int i = 0; i < 4; i++) lane_cnt[i] = 0;
      for (int e = 1; e <= 13; e++) begin
         in_valid = (e <= 6) ? bp_in[e] : 1'b1;
         if (e <= 6 && bp_in[e]) begin
            in_data = mk(b); in_weight = ~mk(b); b++;
         end else begin
            in_data = 32'hEEEEEEEE; in_weight = 32'hEEEEEEEE;
         end
         tick();
         for (int i = 0; i < 4; i++) lane_cnt[i] += int'(pe_valid[i]);
         chk($sformatf("bp%0d_valid", e), 32'(pe_valid), 32'(bp_valid[e]));
         chk($sformatf("bp%0d_done", e),  32'(done), 32'(e == 12));
         chk($sformatf("bp%0d_busy", e),  32'(busy), 32'(e <= 12));
         if (e == 2) chk("bp2_d0", 32'(pe_data[7:0]), 32'h00);
         if (e == 3) chk("bp3_d0", 32'(pe_data[7:0]), 32'h10);
         if (e == 3) chk("bp3_acc", 32'(pe_accumulate_en), 32'h1);
         if (e == 4) chk("bp4_acc", 32'(pe_accumulate_en), 32'h3);
         if (e == 7) chk("bp7_d0", 32'(pe_data[7:0]), 32'h00);
         if (e == 9) chk("bp9_d3", 32'(pe_data[31:24]), 32'h33);
         if (e == 9) chk("bp9_acc", 32'(pe_accumulate_en), 32'h8);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("bp_lane%0d_beats", i), 32'(lane_cnt[i]), 32'd4);
      in_valid = 1'b0;
      tick();

      // Zero-length job.
      start = 1'b1; k_len = 16'd0;
      tick();
      chk("z0_done",  32'(done), 32'd1);
      chk("z0_clr",   32'(pe_clear_acc), 32'hF);
      chk("z0_busy",  32'(busy), 32'd1);
      chk("z0_rdy",   32'(in_ready), 32'd0);
      chk("z0_valid", 32'(pe_valid), 32'd0);
      start = 1'b0;
      tick();
      chk("z1_done",  32'(done), 32'd0);
      chk("z1_busy",  32'(busy), 32'd0);
      chk("z1_clr",   32'(pe_clear_acc), 32'd0);
      chk("z1_valid", 32'(pe_valid), 32'd0);

      // Start pulsed with k_len=9 during the FEED of a k_len=2 job.
      start = 1'b1; k_len = 16'd2; in_valid = 1'b1; in_data = mk(5); in_weight = ~mk(5);
      tick();                                              // edge 0
      k_len = 16'd9;
      for (int i = 0; i < 4; i++) lane_cnt[i] = 0;
      done_cnt = 0;
      clr_cnt  = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 1) start = 1'b0;
         for (int i = 0; i < 4; i++) lane_cnt[i] += int'(pe_valid[i]);
         done_cnt += int'(done);
         clr_cnt  += int'(pe_clear_acc[0]);
      end
      chk("bs_lane0_beats", 32'(lane_cnt[0]), 32'd2);
      chk("bs_lane3_beats", 32'(lane_cnt[3]), 32'd2);
      chk("bs_done_cnt",    32'(done_cnt), 32'd1);
      chk("bs_clr_cnt",     32'(clr_cnt), 32'd0);
      chk("bs_busy",        32'(busy), 32'd0);

      // Reset held two cycles in the middle of FEED.
      start = 1'b1; k_len = 16'd5; in_valid = 1'b1; in_data = mk(7); in_weight = ~mk(7);
      tick();                                              // edge 0
      start = 1'b0;
      tick();
      tick();
      chk("rs_pre_valid", 32'(pe_valid), 32'h3);
      rst = 1'b1;
      tick();
      tick();
      chk_quiet("rs");
      rst = 1'b0;
      stray = 0;
      for (int n = 0; n < 8; n++) begin
         tick();
         stray += int'(pe_valid != '0) + int'(in_ready) + int'(busy);
      end
      chk("rs_after_stray", 32'(stray), 32'd0);
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, operand width; ROWS, default 4, number of skewed lanes; K_WIDTH, default 16, width of k_len; PE_LAT, default 3, downstream MAC pipeline depth used for flush.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, in order (name  direction  width  meaning):
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a job; sampled only in IDLE.
- k_len  input  K_WIDTH  beats in the job; latched on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at job end.
- in_valid  input  1  operand vector present.
- in_ready  output  1  feeder accepts a vector this cycle.
- in_data  input  ROWS*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_weight  input  ROWS*DATA_WIDTH  same packing as in_data.
- pe_data  output  ROWS*DATA_WIDTH  skewed data to MAC lanes.
- pe_weight  output  ROWS*DATA_WIDTH  skewed weights to MAC lanes.
- pe_valid  output  ROWS  per-lane valid.
- pe_accumulate_en  output  ROWS  per-lane accumulate enable.
- pe_clear_acc  output  ROWS  per-lane accumulator clear.

Function
REQ-004 SHALL implement FSM states IDLE, FEED, FLUSH, DONE.
REQ-005 Transitions:
- IDLE->FEED on start with k_len!=0.
- IDLE->DONE on start with k_len==0.
- FEED->FLUSH on the accepted beat that makes the beat count equal k_len.
- FLUSH->DONE after exactly ROWS-1+PE_LAT cycles in FLUSH.
- DONE->IDLE after one cycle.
REQ-006 in_ready SHALL equal (state==FEED), registered/state-derived, with no combinational path from in_valid.
REQ-007 A beat SHALL be accepted when in_valid && in_ready; the beat counter increments by 1 per accepted beat and clears on start.
REQ-008 Lane i outputs (pe_data, pe_weight, pe_valid, pe_accumulate_en) for a beat accepted at edge T SHALL appear in the cycle following edge T+i, i.e. lane 0 latency 1 and lane ROWS-1 latency ROWS.
REQ-009 Bubbles (no accepted beat) SHALL propagate through each lane's skew with pe_valid=0 and pe_data/pe_weight=0, so per-lane gap patterns are identical to the input pattern, only delayed.
REQ-010 pe_accumulate_en for a lane SHALL be 0 with the job's first beat and 1 with every later beat, travelling with the beat; it is 0 whenever pe_valid is 0.
REQ-011 pe_clear_acc SHALL pulse high on all lanes for one cycle in the cycle after start is accepted, including when k_len==0.
REQ-012 start SHALL be ignored when busy=1; k_len changes outside accepted start SHALL have no effect.
REQ-013 done SHALL be high exactly in the DONE cycle; busy SHALL be high in FEED, FLUSH and DONE.
REQ-014 Operand values SHALL be passed unmodified (no sign or width conversion); the beat counter is K_WIDTH bits and does not wrap, because the maximum is bounded by k_len.

Reset
REQ-015 rst SHALL, at the next edge regardless of state, force IDLE, clear the beat counter, and zero all skew registers.
REQ-016 After rst: busy, done, in_ready, pe_valid, pe_accumulate_en, pe_clear_acc, pe_data and pe_weight SHALL all read 0.
REQ-017 rst mid-job SHALL discard all in-flight beats; no pe_valid SHALL appear afterwards until a new job.

Verification
REQ-018 Reset: assert rst 2 cycles during FEED -> next cycle all outputs 0, state IDLE, in_ready=0.
REQ-019 Streaming (ROWS=4, PE_LAT=3): start, k_len=3, in_valid held high, lane i of beat b = 16*b+i -> clear pulse cycle 1 after start; beats accepted on edges 1..3; lane3 shows 3,19,35 with accumulate_en 0,1,1; FLUSH 6 cycles; done one cycle.
REQ-020 Backpressure: k_len=4, in_valid pattern 1,0,1,1,0,1 -> every lane shows the same valid/bubble pattern skewed by i, 4 valid beats per lane, done after the 4th beat plus 6 flush cycles.
REQ-021 Zero-length: start with k_len=0 -> clear pulse and done in the cycle after start, no pe_valid, IDLE next.
REQ-022 Busy start: pulse start with k_len=9 during FEED of a k_len=2 job -> ignored; exactly 2 beats accepted; single done.
